// File: rtl/puf_key_collector.sv
// puf_key_collector: drives an arbiter PUF through clear/launch/settle/sample
// cycles, walks a 16-bit LFSR challenge sequence, and shifts the resolved
// response bits into a KEY_BITS-wide key.
// Optional feature: define PUF_MAJORITY_VOTE_EN to resolve each key bit by
// majority over VOTES evaluations. The default build uses one evaluation per
// bit, and VOTES then only sizes the counters.
//
// state  | meaning
// IDLE   | waiting for start, arbiter held in reset
// CLEAR  | arbiter capture flop cleared for CLR_CYC cycles
// LAUNCH | race edge launched into both paths (1 cycle)
// SETTLE | race resolving, SETTLE_CYC cycles
// SAMPLE | synchronized response counted as one vote
// NEXT   | bit resolved, shifted into key, LFSR advanced
// DONE   | key complete and held until the next start
module puf_key_collector #(
  parameter int          KEY_BITS   = 128,
  parameter int          VOTES      = 5,
  parameter int          CLR_CYC    = 2,
  parameter int          SETTLE_CYC = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                puf_out,
  output logic                puf_in,
  output logic                puf_reset,
  output logic [15:0]         challenge,
  output logic [KEY_BITS-1:0] key,
  output logic                key_valid,
  output logic                busy
);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VE = VOTES;
`else
  localparam int VE = 1;
`endif
  localparam int TMAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int VW   = $clog2(VOTES + 1) + 1;
  localparam int BW   = $clog2(KEY_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, NEXT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [VW-1:0]       votes_q, votes_d;
  logic [VW-1:0]       ones_q, ones_d;
  logic [BW-1:0]       bits_q, bits_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [15:0]         chal_q, chal_d;
  logic                kv_q, kv_d;
  logic                busy_q, busy_d;
  logic                pin_q, pin_d;
  logic                prst_q, prst_d;
  logic [1:0]          sync_q;
  logic                bit_res;
  logic                lfsr_fb;

  assign lfsr_fb = chal_q[15] ^ chal_q[13] ^ chal_q[12] ^ chal_q[10];
  assign bit_res = (ones_q > VW'(VE / 2));

  // Next-state logic; outputs are derived from the next state so they register
  // in lock-step with the state they belong to.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    votes_d = votes_q;
    ones_d  = ones_q;
    bits_d  = bits_q;
    key_d   = key_q;
    chal_d  = chal_q;
    kv_d    = kv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CLEAR;
          timer_d = TW'(CLR_CYC - 1);
          votes_d = '0;
          ones_d  = '0;
          bits_d  = '0;
          key_d   = '0;
          kv_d    = 1'b0;
          chal_d  = SEED;
        end
      end
      CLEAR: begin
        if (timer_q == '0) state_d = LAUNCH;
        else               timer_d = timer_q - 1'b1;
      end
      LAUNCH: begin
        state_d = SETTLE;
        timer_d = TW'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (timer_q == '0) state_d = SAMPLE;
        else               timer_d = timer_q - 1'b1;
      end
      SAMPLE: begin
        ones_d  = ones_q + VW'(sync_q[1]);
        votes_d = votes_q + 1'b1;
        if (votes_q == VW'(VE - 1)) begin
          state_d = NEXT;
        end else begin
          state_d = CLEAR;
          timer_d = TW'(CLR_CYC - 1);
        end
      end
      NEXT: begin
        key_d   = {key_q[KEY_BITS-2:0], bit_res};
        ones_d  = '0;
        votes_d = '0;
        chal_d  = {chal_q[14:0], lfsr_fb};
        bits_d  = bits_q + 1'b1;
        if (bits_q == BW'(KEY_BITS - 1)) begin
          state_d = DONE;
          kv_d    = 1'b1;
        end else begin
          state_d = CLEAR;
          timer_d = TW'(CLR_CYC - 1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, DONE});
    pin_d  = (state_d inside {LAUNCH, SETTLE, SAMPLE});
    prst_d = (state_d inside {IDLE, CLEAR, NEXT, DONE});
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      votes_q <= '0;
      ones_q  <= '0;
      bits_q  <= '0;
      key_q   <= '0;
      chal_q  <= SEED;
      kv_q    <= 1'b0;
      busy_q  <= 1'b0;
      pin_q   <= 1'b0;
      prst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      votes_q <= votes_d;
      ones_q  <= ones_d;
      bits_q  <= bits_d;
      key_q   <= key_d;
      chal_q  <= chal_d;
      kv_q    <= kv_d;
      busy_q  <= busy_d;
      pin_q   <= pin_d;
      prst_q  <= prst_d;
    end
  end

  // Free-running two-flop synchronizer for the asynchronous arbiter response.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], puf_out};
  end

  assign puf_in    = pin_q;
  assign puf_reset = prst_q;
  assign challenge = chal_q;
  assign key       = key_q;
  assign key_valid = kv_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_puf_key_collector.sv
// Testbench for puf_key_collector: an arbiter model answers each launch
// according to the selected mode, a reference model predicts the key, and a
// scoreboard compares key and latency whenever key_valid rises.
module tb_puf_key_collector;

  localparam int          KB    = 128;
  localparam int          VOTES = 5;
  localparam int          CLR   = 2;
  localparam int          SET   = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VE = VOTES;
`else
  localparam int VE = 1;
`endif
  localparam int LAT = KB * (VE * (CLR + SET + 2) + 1) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           puf_out = 1'b0;
  logic           puf_in, puf_reset, key_valid, busy;
  logic [15:0]    challenge;
  logic [KB-1:0]  key;

  puf_key_collector #(
    .KEY_BITS(KB), .VOTES(VOTES), .CLR_CYC(CLR), .SETTLE_CYC(SET), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .puf_out(puf_out),
    .puf_in(puf_in), .puf_reset(puf_reset), .challenge(challenge),
    .key(key), .key_valid(key_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] seq [0:KB];
  bit          rnd [KB*15];
  int          mode = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] c);
    return {c[14:0], c[15] ^ c[13] ^ c[12] ^ c[10]};
  endfunction

  // Which evaluation within a bit the disturbing arbiter model inverts.
  function automatic bit flip_vote(input int k);
`ifdef PUF_MAJORITY_VOTE_EN
    return (k == 1 || k == 3);
`else
    return (k == 0);
`endif
  endfunction

  // Arbiter answer for evaluation n (vote k of its bit) given challenge bit 0.
  function automatic bit eval_val(input int m, input bit cbit, input int n, input int k);
    case (m)
      0:       return 1'b1;
      1:       return cbit;
      2:       return cbit ^ flip_vote(k);
      default: return rnd[n];
    endcase
  endfunction

  function automatic logic [127:0] model_key(input int m);
    logic [127:0] kk = '0;
    logic [15:0]  c  = SEED;
    int           ones;
    for (int b = 0; b < KB; b++) begin
      ones = 0;
      for (int k = 0; k < VE; k++) ones += int'(eval_val(m, c[0], b * VE + k, k));
      kk[KB-1-b] = (ones > VE / 2);
      c = lfsr_step(c);
    end
    return kk;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] key;
    int           c0;
  } exp_t;
  exp_t sb_q[$];
  int   n_seen = 0;
  logic kv_prev = 1'b0;

  // Monitor: every rising key_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset) kv_prev = 1'b0;
    else begin
      if (key_valid && !kv_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_key_valid: got key_valid=1 expected no pending key");
        end else begin
          e = sb_q.pop_front();
          chk("key", key, e.key);
          chk("latency", cyc - e.c0 + 1, LAT);
          chk("busy_done", busy, 1'b0);
        end
        n_seen++;
      end
      kv_prev = key_valid;
    end
  end

  // ---------------- arbiter model + launch timing monitor ----------------
  int launch_n = 0;
  bit aborting = 1'b0;
  int hi_run = 0, clr_run = 0, drv_b = 0, drv_k = 0;
  bit prev_in = 1'b0, rst_bad = 1'b0;

  always @(negedge clk) begin
    if (reset || aborting) begin
      hi_run = 0; clr_run = 0; prev_in = 1'b0; rst_bad = 1'b0;
    end else begin
      if (puf_in && !prev_in) begin
        drv_b = launch_n / VE;
        drv_k = launch_n % VE;
        chk("clear_gap", (drv_k == 0) ? (clr_run >= CLR) : (clr_run == CLR), 1'b1);
        chk("busy_eval", busy, 1'b1);
        if (drv_b < KB) chk("challenge", challenge, seq[drv_b]);
        else begin
          n_checks++;
          $display("FAIL extra_launch: got launch %0d expected at most %0d", launch_n, KB * VE);
        end
        puf_out = eval_val(mode, challenge[0], launch_n, drv_k);
        launch_n++;
        hi_run  = 0;
        rst_bad = 1'b0;
      end
      if (puf_in) begin
        hi_run++;
        if (puf_reset) rst_bad = 1'b1;
        clr_run = 0;
      end else begin
        if (prev_in) begin
          chk("eval_high_len", (hi_run >= SET + 1 && hi_run <= SET + 2), 1'b1);
          chk("reset_low_in_eval", rst_bad, 1'b0);
        end
        if (puf_reset) clr_run++;
        else           clr_run = 0;
      end
      prev_in = puf_in;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_puf_in"}, puf_in, 1'b0);
    chk({tag, "_puf_reset"}, puf_reset, 1'b1);
    chk({tag, "_challenge"}, challenge, SEED);
    chk({tag, "_key"}, key, '0);
    chk({tag, "_key_valid"}, key_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_start(input logic [127:0] e);
    exp_t it;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    launch_n = 0;
    chk("start_kv_drop", key_valid, 1'b0);
    chk("start_busy", busy, 1'b1);
    chk("start_challenge", challenge, SEED);
    chk("start_key_clear", key, '0);
    it.key = e;
    it.c0  = cyc;
    sb_q.push_back(it);
  endtask

  task automatic run_key(input int m, input bit mid_start);
    logic [127:0] e;
    int  seen0;
    bit  done = 1'b0;
    mode = m;
    if (m == 3) foreach (rnd[i]) rnd[i] = bit'($urandom_range(0, 1));
    e = model_key(m);
    do_start(e);
    seen0 = n_seen;
    for (int i = 0; i < LAT + 50; i++) begin
      @(negedge clk);
      start = (mid_start && i == 1000);
      if (n_seen != seen0) begin done = 1'b1; break; end
    end
    start = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL timeout: got no key_valid expected within %0d cycles", LAT + 50);
      sb_q.delete();
    end else begin
      repeat (4) @(negedge clk);
      chk("key_hold", key, e);
      chk("kv_hold", key_valid, 1'b1);
    end
  endtask

  initial begin
    bit reached = 1'b0;
    seq[0] = SEED;
    for (int b = 0; b < KB; b++) seq[b+1] = lfsr_step(seq[b]);

    // reset held with start asserted: reset must win
    reset = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    run_key(0, 1'b0);   // arbiter tied to 1
    run_key(1, 1'b0);   // arbiter answers challenge[0]
    run_key(2, 1'b0);   // challenge[0] with disturbed votes
    run_key(3, 1'b1);   // random answers, start pulsed mid-collection

    // abort during bit 40
    mode = 0;
    do_start(model_key(0));
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (launch_n > 40 * VE) begin reached = 1'b1; break; end
    end
    chk("abort_reached_bit40", reached, 1'b1);
    aborting = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    aborting = 1'b0;

    run_key(1, 1'b0);   // full run after abort

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
